strobe_multi: RTL and testbench
===============================

STROBE_MULTI -- requirements
Module: strobe_multi

Interface
REQ-001 SHALL have parameter N_CHAN, default 4, number of independent strobe channels (1..4).
REQ-002 SHALL have parameter CTRL_PERIOD_W, default 16, width of period and phase controls.
REQ-003 SHALL have parameter CTRL_WIDTH_W, default 8, width of the pulse-width control.
REQ-004 SHALL have parameter CTRL_JITTER_W, default 6, width of the jitter control (1..7).
REQ-005 SHALL have ports: i_clk  in  1  clock, the only clock.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_cg  in  1  clock gate; low means all state holds.
REQ-008 SHALL have port i_ctrlPeriodM1  in  N_CHAN*CTRL_PERIOD_W  per-channel period minus 1.
REQ-009 SHALL have port i_ctrlPhase  in  N_CHAN*CTRL_PERIOD_W  per-channel delay from start to first pulse.
REQ-010 SHALL have port i_ctrlWidthM1  in  N_CHAN*CTRL_WIDTH_W  per-channel pulse high time minus 1.
REQ-011 SHALL have port i_ctrlOneShot  in  N_CHAN  per-channel: 1 means single pulse, then idle.
REQ-012 SHALL have port i_ctrlJitter  in  CTRL_JITTER_W  jitter probability threshold, shared; 0 means no jitter.
REQ-013 SHALL have port i_start  in  N_CHAN  per-channel start/restart request.
REQ-014 SHALL have port i_stop  in  N_CHAN  per-channel stop request.
REQ-015 SHALL have port i_jitterSeed  in  32  PRNG seed value.
REQ-016 SHALL have port i_jitterSeedValid  in  1  load i_jitterSeed into the PRNG.
REQ-017 SHALL have port o_jitterPrng  out  32  current PRNG state.
REQ-018 SHALL have port o_strobe  out  N_CHAN  registered strobe outputs.
REQ-019 SHALL have port o_busy  out  N_CHAN  registered; 1 while the channel is not IDLE or its pulse is still high.

Function
REQ-020 SHALL update all state only on i_clk cycles where i_cg=1; inputs are sampled only in those cycles.
REQ-021 Each channel SHALL run an FSM with states IDLE, PHASE and RUN, plus a down counter of CTRL_PERIOD_W bits and a width counter.
REQ-022 When i_start[k] is sampled high in any state, the channel SHALL enter PHASE with counter = i_ctrlPhase[k] (restart).
REQ-023 i_stop[k] SHALL take priority over i_start[k]: it forces IDLE, clears the width counter, and drives o_strobe[k]=0 in the next cycle.
REQ-024 A boundary occurs in PHASE or RUN when counter==0: counter loads i_ctrlPeriodM1[k], the state becomes RUN, and the width counter loads i_ctrlWidthM1[k].
REQ-025 With i_ctrlOneShot[k]=1, a boundary SHALL move the channel to IDLE instead of RUN; the pulse still completes its full width.
REQ-026 Otherwise the counter SHALL decrement by 1 per cycle.
REQ-027 o_strobe[k] SHALL be high from the cycle after a boundary, for i_ctrlWidthM1[k]+1 cycles.
REQ-028 A boundary during an active pulse SHALL reload the width counter; if WidthM1 >= PeriodM1, o_strobe stays continuously high.
REQ-029 Latency: with i_start at cycle t and phase P, the first o_strobe rises at cycle t+P+2; later rises occur every PeriodM1+1 cycles.
REQ-030 PeriodM1=0 SHALL give a boundary every cycle.
REQ-031 Control changes SHALL take effect at the next reload; they SHALL NOT alter a running count.

Reset
REQ-032 While i_rst_n=0, asynchronously: all channels IDLE, counters 0, o_strobe=0, o_busy=0, PRNG state 32'h00000001.
REQ-033 Reset deassertion mid-operation SHALL leave every channel IDLE until a new i_start; no spurious pulse.

Configuration
REQ-034 Macro STROBE_MULTI_JITTER_EN defined: the module includes a shared xorshift32 PRNG (shifts 13/17/5), advancing every i_cg cycle.
REQ-035 i_jitterSeedValid=1 SHALL load i_jitterSeed, with a seed of 0 replaced by 1; seed load takes priority over advancing.
REQ-036 Channel k SHALL jitter in RUN when prng[8k +: CTRL_JITTER_W] < i_ctrlJitter.
REQ-037 For a jittering channel, prng[8k+7]=1 means extend: the counter holds.
REQ-038 For a jittering channel, prng[8k+7]=0 means shorten: the counter decrements by 2, or by 1 if counter==1.
REQ-039 Jitter SHALL never apply in PHASE or on the boundary cycle.
REQ-040 Macro undefined: no PRNG, o_jitterPrng=0, i_ctrlJitter/i_jitterSeed/i_jitterSeedValid ignored, periods exact.

Verification
REQ-041 Periodic mode: PeriodM1=9, Phase=3, WidthM1=1, start at cycle 10 -> o_strobe high at cycles 15-16, 25-26, 35-36.
REQ-042 One-shot mode: OneShot=1, Phase=0, WidthM1=4, start -> one 5-cycle pulse, then o_busy falls and there is no further pulse.
REQ-043 Stop/start collisions: start+stop in the same cycle -> channel stays IDLE; stop mid-pulse -> o_strobe low in the next cycle.
REQ-044 Width vs period: WidthM1=7, PeriodM1=3 -> o_strobe constantly high after the first rise; WidthM1=0, PeriodM1=0 -> high every cycle.
REQ-045 Jitter (macro on): seed 32'hDEADBEEF, i_ctrlJitter=0 -> exact period; max jitter over 10000 cycles -> mean period within 2% of PeriodM1+1, with both extended and shortened intervals seen.
REQ-046 Clock gate and reset: i_cg=0 for 5 cycles mid-run -> all outputs and o_jitterPrng frozen; i_rst_n pulsed low mid-pulse -> o_strobe=0 immediately, and it stays idle after release.

Source files
------------

// File: rtl/strobe_multi_if.sv
// strobe_multi_if: control, seed and strobe bundle for strobe_multi.
// master = controller side (drives controls, observes strobes),
// slave  = strobe_multi side.
interface strobe_multi_if #(
   parameter int N_CHAN        = 4,
   parameter int CTRL_PERIOD_W = 16,
   parameter int CTRL_WIDTH_W  = 8,
   parameter int CTRL_JITTER_W = 6
);
   logic                                    i_cg;
   logic [N_CHAN-1:0][CTRL_PERIOD_W-1:0]    i_ctrlPeriodM1;
   logic [N_CHAN-1:0][CTRL_PERIOD_W-1:0]    i_ctrlPhase;
   logic [N_CHAN-1:0][CTRL_WIDTH_W-1:0]     i_ctrlWidthM1;
   logic [N_CHAN-1:0]                       i_ctrlOneShot;
   logic [CTRL_JITTER_W-1:0]                i_ctrlJitter;
   logic [N_CHAN-1:0]                       i_start;
   logic [N_CHAN-1:0]                       i_stop;
   logic [31:0]                             i_jitterSeed;
   logic                                    i_jitterSeedValid;
   logic [31:0]                             o_jitterPrng;
   logic [N_CHAN-1:0]                       o_strobe;
   logic [N_CHAN-1:0]                       o_busy;

   modport master (
      output i_cg, i_ctrlPeriodM1, i_ctrlPhase, i_ctrlWidthM1, i_ctrlOneShot,
             i_ctrlJitter, i_start, i_stop, i_jitterSeed, i_jitterSeedValid,
      input  o_jitterPrng, o_strobe, o_busy
   );

   modport slave (
      input  i_cg, i_ctrlPeriodM1, i_ctrlPhase, i_ctrlWidthM1, i_ctrlOneShot,
             i_ctrlJitter, i_start, i_stop, i_jitterSeed, i_jitterSeedValid,
      output o_jitterPrng, o_strobe, o_busy
   );
endinterface

// File: rtl/strobe_multi.sv
// strobe_multi: N_CHAN independent periodic / one-shot strobe generators.
// Each channel: IDLE -> PHASE (initial delay) -> RUN (periodic boundaries).
// A boundary fires when the down counter hits 0; the pulse starts the next
// cycle and lasts WidthM1+1 cycles. Everything holds while i_cg is low.
// Optional macro STROBE_MULTI_JITTER_EN adds a shared xorshift32 PRNG that
// randomly stretches or shrinks RUN intervals; without it periods are exact
// and o_jitterPrng reads 0.

// One strobe channel.
module strobe_chan #(
   parameter int PW = 16,
   parameter int WW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cg,
   input  logic          start,
   input  logic          stop,
   input  logic          one_shot,
   input  logic [PW-1:0] period_m1,
   input  logic [PW-1:0] phase,
   input  logic [WW-1:0] width_m1,
   input  logic          jit,
   input  logic          jit_ext,
   output logic          strobe,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, PHASE = 2'd1, RUN = 2'd2} state_t;

   state_t        st;
   logic [PW-1:0] cnt;
   logic [WW-1:0] wcnt;

   // Channel FSM, period counter and pulse-width counter. The pulse tail is
   // handled first so a later boundary in the same cycle can reload it, and
   // so one-shot / restart never cut a pulse short (only stop does).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= IDLE;
         cnt    <= '0;
         wcnt   <= '0;
         strobe <= 1'b0;
         busy   <= 1'b0;
      end else if (cg) begin
         if (stop) begin
            st     <= IDLE;
            cnt    <= '0;
            wcnt   <= '0;
            strobe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            if (strobe) begin
               if (wcnt == '0) strobe <= 1'b0;
               else            wcnt   <= wcnt - WW'(1);
            end
            if (start) begin
               st   <= PHASE;
               cnt  <= phase;
               busy <= 1'b1;
            end else if (st != IDLE && cnt == '0) begin
               st     <= one_shot ? IDLE : RUN;
               cnt    <= period_m1;
               wcnt   <= width_m1;
               strobe <= 1'b1;
               busy   <= 1'b1;
            end else begin
               if (st == RUN && jit) begin
                  // extend holds the count; shorten skips one step
                  if (!jit_ext) cnt <= (cnt == PW'(1)) ? '0 : cnt - PW'(2);
               end else if (st != IDLE) begin
                  cnt <= cnt - PW'(1);
               end
               busy <= (st != IDLE) || (strobe && wcnt != '0);
            end
         end
      end
   end
endmodule

module strobe_multi #(
   parameter int N_CHAN        = 4,
   parameter int CTRL_PERIOD_W = 16,
   parameter int CTRL_WIDTH_W  = 8,
   parameter int CTRL_JITTER_W = 6
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   strobe_multi_if.slave bus
);
   logic [N_CHAN-1:0] strobe;
   logic [N_CHAN-1:0] busy;
   logic [N_CHAN-1:0] jit;
   logic [N_CHAN-1:0] jit_ext;

`ifdef STROBE_MULTI_JITTER_EN
   logic [31:0] prng;

   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Shared PRNG: seed load wins over advancing; 0 would lock xorshift up.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prng <= 32'h0000_0001;
      end else if (bus.i_cg) begin
         if (bus.i_jitterSeedValid)
            prng <= (bus.i_jitterSeed == 32'h0) ? 32'h0000_0001 : bus.i_jitterSeed;
         else
            prng <= xs32(prng);
      end
   end

   assign bus.o_jitterPrng = prng;

   // Each channel draws its own byte of the PRNG word.
   for (genvar k = 0; k < N_CHAN; k++) begin : g_jit
      assign jit[k]     = prng[8*k +: CTRL_JITTER_W] < bus.i_ctrlJitter;
      assign jit_ext[k] = prng[8*k+7];
   end
`else
   logic unused_jitter;

   assign unused_jitter    = ^{bus.i_ctrlJitter, bus.i_jitterSeed, bus.i_jitterSeedValid};
   assign bus.o_jitterPrng = 32'h0;
   assign jit              = '0;
   assign jit_ext          = '0;
`endif

   for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
      strobe_chan #(
         .PW (CTRL_PERIOD_W),
         .WW (CTRL_WIDTH_W)
      ) u_chan (
         .clk       (i_clk),
         .rst_n     (i_rst_n),
         .cg        (bus.i_cg),
         .start     (bus.i_start[k]),
         .stop      (bus.i_stop[k]),
         .one_shot  (bus.i_ctrlOneShot[k]),
         .period_m1 (bus.i_ctrlPeriodM1[k]),
         .phase     (bus.i_ctrlPhase[k]),
         .width_m1  (bus.i_ctrlWidthM1[k]),
         .jit       (jit[k]),
         .jit_ext   (jit_ext[k]),
         .strobe    (strobe[k]),
         .busy      (busy[k])
      );
   end

   assign bus.o_strobe = strobe;
   assign bus.o_busy   = busy;
endmodule

// File: tb/tb_strobe_multi.sv
// tb_strobe_multi: timeline model (absolute boundary / pulse-end times per
// channel) compared against strobe_multi every cycle, plus directed
// literal scenarios and, with STROBE_MULTI_JITTER_EN, jitter statistics.
module tb_strobe_multi;
   localparam int N  = 4;
   localparam int PW = 16;
   localparam int WW = 8;
   localparam int JW = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   strobe_multi_if #(.N_CHAN(N), .CTRL_PERIOD_W(PW), .CTRL_WIDTH_W(WW), .CTRL_JITTER_W(JW)) bus ();

   strobe_multi #(.N_CHAN(N), .CTRL_PERIOD_W(PW), .CTRL_WIDTH_W(WW), .CTRL_JITTER_W(JW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // ---------------- timeline model ----------------
   // m_e: index of the latest enabled edge. m_nb: edge at which the next
   // boundary happens. m_pl: last edge after which the strobe is high.
   bit          m_act [N];
   bit          m_run [N];
   longint      m_nb  [N];
   longint      m_pl  [N];
   longint      m_e    = 0;
   logic [31:0] m_prng = 32'h1;

   function automatic bit jit_hit(input int k);
`ifdef STROBE_MULTI_JITTER_EN
      return m_prng[8*k +: JW] < bus.i_ctrlJitter;
`else
      return (k < 0);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            m_act[k] = 0; m_run[k] = 0; m_nb[k] = 0; m_pl[k] = -1;
         end
         m_prng = 32'h1;
      end else if (bus.i_cg) begin
         m_e++;
         for (int k = 0; k < N; k++) begin
            if (bus.i_stop[k]) begin
               m_act[k] = 0;
               if (m_pl[k] >= m_e) m_pl[k] = m_e - 1;
            end else if (bus.i_start[k]) begin
               m_act[k] = 1;
               m_run[k] = 0;
               m_nb[k]  = m_e + 1 + longint'(bus.i_ctrlPhase[k]);
            end else if (m_act[k] && m_e == m_nb[k]) begin
               m_pl[k]  = m_e + longint'(bus.i_ctrlWidthM1[k]);
               m_nb[k]  = m_e + 1 + longint'(bus.i_ctrlPeriodM1[k]);
               m_run[k] = 1;
               if (bus.i_ctrlOneShot[k]) m_act[k] = 0;
            end else if (m_act[k] && m_run[k] && jit_hit(k)) begin
               if (m_prng[8*k+7])         m_nb[k]++;
               else if (m_nb[k] - m_e >= 2) m_nb[k]--;
            end
         end
         if (bus.i_jitterSeedValid) m_prng = (bus.i_jitterSeed == 0) ? 32'h1 : bus.i_jitterSeed;
         else                       m_prng = xs32(m_prng);
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin : cmp
      logic [N-1:0] es, eb;
      logic [31:0]  ep;
      for (int k = 0; k < N; k++) begin
         es[k] = (m_pl[k] >= m_e);
         eb[k] = m_act[k] || es[k];
      end
`ifdef STROBE_MULTI_JITTER_EN
      ep = m_prng;
`else
      ep = 32'h0;
`endif
      chk("model_strobe", 64'(bus.o_strobe), 64'(es));
      chk("model_busy",   64'(bus.o_busy),   64'(eb));
      chk("model_prng",   64'(bus.o_jitterPrng), 64'(ep));
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_ch(input int k, input int pm1, input int ph, input int w, input bit os);
      bus.i_ctrlPeriodM1[k] = PW'(pm1);
      bus.i_ctrlPhase[k]    = PW'(ph);
      bus.i_ctrlWidthM1[k]  = WW'(w);
      bus.i_ctrlOneShot[k]  = os;
   endtask

   // Called at a negedge: pulses start/stop for one edge, then records
   // channel 0 after each of the next n edges (bit j = after edge t+j).
   task automatic run_rec(input logic [N-1:0] st, input logic [N-1:0] sp, input int n,
                          output logic [63:0] s, output logic [63:0] b);
      bus.i_start = st;
      bus.i_stop  = sp;
      s = '0;
      b = '0;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         bus.i_start = '0;
         bus.i_stop  = '0;
         s[j] = bus.o_strobe[0];
         b[j] = bus.o_busy[0];
      end
   endtask

   logic [63:0] rs, rb;
   logic [31:0] prst;

   initial begin
`ifdef STROBE_MULTI_JITTER_EN
      prst = 32'h1;
`else
      prst = 32'h0;
`endif
      bus.i_cg = 1'b1;
      bus.i_ctrlPeriodM1 = '0; bus.i_ctrlPhase = '0; bus.i_ctrlWidthM1 = '0;
      bus.i_ctrlOneShot = '0; bus.i_ctrlJitter = '0;
      bus.i_start = '0; bus.i_stop = '0;
      bus.i_jitterSeed = '0; bus.i_jitterSeedValid = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_strobe", 64'(bus.o_strobe), 64'h0);
      chk("reset_busy",   64'(bus.o_busy),   64'h0);
      chk("reset_prng",   64'(bus.o_jitterPrng), 64'(prst));
      rst_n = 1'b1;
      @(negedge clk);

      // periodic: phase 3, period 10, width 2
      set_ch(0, 9, 3, 1, 0);
      run_rec(4'b0001, 4'b0000, 30, rs, rb);
      chk("periodic", rs, 64'h0300_C030);
      run_rec(4'b0000, 4'b0001, 2, rs, rb);

      // one-shot: single 5-cycle pulse, busy drops right after it
      set_ch(0, 9, 0, 4, 1);
      run_rec(4'b0001, 4'b0000, 20, rs, rb);
      chk("oneshot_strobe", rs, 64'h3E);
      chk("oneshot_busy",   rb, 64'h3F);

      // start and stop together: stop wins
      run_rec(4'b0001, 4'b0001, 10, rs, rb);
      chk("startstop_strobe", rs, 64'h0);
      chk("startstop_busy",   rb, 64'h0);

      // stop mid-pulse
      set_ch(0, 9, 0, 5, 0);
      run_rec(4'b0001, 4'b0000, 3, rs, rb);
      chk("prestop_strobe", rs, 64'h6);
      chk("prestop_busy",   rb, 64'h7);
      run_rec(4'b0000, 4'b0001, 4, rs, rb);
      chk("stop_strobe", rs, 64'h0);
      chk("stop_busy",   rb, 64'h0);

      // width longer than period: continuous high
      set_ch(0, 3, 0, 7, 0);
      run_rec(4'b0001, 4'b0000, 40, rs, rb);
      chk("wide_pulse", rs, 64'hFF_FFFF_FFFE);
      run_rec(4'b0000, 4'b0001, 2, rs, rb);

      // period 1, width 1: high every cycle
      set_ch(0, 0, 0, 0, 0);
      run_rec(4'b0001, 4'b0000, 20, rs, rb);
      chk("every_cycle", rs, 64'hF_FFFE);
      run_rec(4'b0000, 4'b0001, 2, rs, rb);

      // clock gate freeze mid-pulse
      set_ch(0, 4, 0, 1, 0);
      run_rec(4'b0001, 4'b0000, 2, rs, rb);
      chk("cg_pre", rs, 64'h2);
      bus.i_cg = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("cg_freeze_strobe", 64'(bus.o_strobe[0]), 64'h1);
         chk("cg_freeze_busy",   64'(bus.o_busy[0]),   64'h1);
      end
      bus.i_cg = 1'b1;
      run_rec(4'b0000, 4'b0000, 6, rs, rb);
      chk("cg_resume", rs, 64'h31);

      // async reset mid-pulse, then stay idle
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_strobe", 64'(bus.o_strobe), 64'h0);
      chk("rst_async_busy",   64'(bus.o_busy),   64'h0);
      chk("rst_async_prng",   64'(bus.o_jitterPrng), 64'(prst));
      @(negedge clk);
      rst_n = 1'b1;
      run_rec(4'b0000, 4'b0000, 20, rs, rb);
      chk("post_rst_strobe", rs, 64'h0);
      chk("post_rst_busy",   rb, 64'h0);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bus.i_cg = ($urandom_range(0, 9) != 0);
         for (int k = 0; k < N; k++) begin
            bus.i_start[k] = ($urandom_range(0, 15) == 0);
            bus.i_stop[k]  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0)
               set_ch(k, $urandom_range(0, 12), $urandom_range(0, 10),
                      $urandom_range(0, 12), ($urandom_range(0, 3) == 0));
         end
         if ($urandom_range(0, 49) == 0) bus.i_ctrlJitter = JW'($urandom);
         bus.i_jitterSeedValid = ($urandom_range(0, 199) == 0);
         bus.i_jitterSeed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      bus.i_cg = 1'b1;
      bus.i_start = '0;
      bus.i_jitterSeedValid = 1'b0;
      bus.i_ctrlJitter = '0;
      run_rec(4'b0000, 4'b1111, 2, rs, rb);

`ifdef STROBE_MULTI_JITTER_EN
      begin : jitter_tests
         int     last [N];
         bit     seen [N];
         bit     prev [N];
         longint sum;
         int     cnt;
         bit     ext_seen, shr_seen;
         real    mean;

         // seed load, including the zero-seed substitution
         bus.i_jitterSeed = 32'hDEAD_BEEF; bus.i_jitterSeedValid = 1'b1;
         @(negedge clk);
         chk("seed_load", 64'(bus.o_jitterPrng), 64'hDEAD_BEEF);
         bus.i_jitterSeed = 32'h0;
         @(negedge clk);
         chk("seed_zero", 64'(bus.o_jitterPrng), 64'h1);
         bus.i_jitterSeed = 32'hDEAD_BEEF;
         @(negedge clk);
         bus.i_jitterSeedValid = 1'b0;

         // jitter threshold 0: exact period
         set_ch(0, 9, 0, 0, 0);
         run_rec(4'b0001, 4'b0000, 40, rs, rb);
         chk("nojitter_exact", rs, 64'h8020_0802);
         run_rec(4'b0000, 4'b1111, 2, rs, rb);

         // maximum jitter, all channels, even PeriodM1
         for (int k = 0; k < N; k++) begin
            set_ch(k, 20, 0, 0, 0);
            seen[k] = 0; prev[k] = 0; last[k] = 0;
         end
         sum = 0; cnt = 0; ext_seen = 0; shr_seen = 0;
         bus.i_ctrlJitter = '1;
         bus.i_start = '1;
         for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            bus.i_start = '0;
            for (int k = 0; k < N; k++) begin
               if (bus.o_strobe[k] && !prev[k]) begin
                  if (seen[k]) begin
                     sum += i - last[k];
                     cnt++;
                     if (i - last[k] > 21) ext_seen = 1;
                     if (i - last[k] < 21) shr_seen = 1;
                  end
                  seen[k] = 1;
                  last[k] = i;
               end
               prev[k] = bus.o_strobe[k];
            end
         end
         mean = (cnt > 0) ? real'(sum) / real'(cnt) : 0.0;
         checks++;
         if (mean < 21.0 * 0.98 || mean > 21.0 * 1.02) begin
            errors++;
            $display("FAIL jitter_mean got=%f exp=21.0 within 2%%", mean);
         end
         chk("jitter_extend_seen",  64'(ext_seen), 64'h1);
         chk("jitter_shorten_seen", 64'(shr_seen), 64'h1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
